// File: rtl/uart_mmio_pkg.sv
// Shared bus payloads and UART constants for the memory-mapped UART peripheral.
package uart_mmio_pkg;

    localparam int unsigned BUS_WIDTH        = 32;
    localparam int unsigned DIV_W            = 16;
    localparam int unsigned UART_DEFAULT_DIV = 434;
    localparam int unsigned UART_MIN_DIV     = 4;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_RXDATA  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_BAUDDIV = 2'd3;

    localparam int unsigned ST_TX_BUSY   = 0;
    localparam int unsigned ST_RX_VALID  = 1;
    localparam int unsigned ST_OVERRUN   = 2;
    localparam int unsigned ST_FRAME_ERR = 3;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

    typedef struct packed {
        logic                 sel;
        logic [BUS_WIDTH-1:0] dbus;
        logic [BUS_WIDTH-1:0] dbus_addr;
        logic                 wr_en;
        logic                 rd_en;
    } type_lsu2module_data_s;

    typedef struct packed {
        logic [BUS_WIDTH-1:0] rd_data;
    } type_module2lsu_s;

    // Divisors below the minimum cannot give a usable mid-bit sample point.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : d;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: input synchroniser, 8N1 deserialiser, registered byte/frame-error pulses.
module uart_rx_core
    import uart_mmio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             byte_done_o,
    output logic [7:0]       byte_o,
    output logic             frame_err_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    uart_state_e            state_q, state_d;
    logic [DIV_W-1:0]       cnt_q, cnt_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             byte_q, byte_d;
    logic                   armed_q, armed_d;
    logic                   done_q, done_d;
    logic                   ferr_q, ferr_d;
    logic                   wrap;
    logic                   half;

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign wrap = (cnt_q == (div_q - DIV_W'(1)));
    assign half = (cnt_q == ((div_q >> 1) - DIV_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '1;
            state_q <= UART_IDLE;
            cnt_q   <= '0;
            div_q   <= DIV_W'(UART_DEFAULT_DIV);
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            armed_q <= armed_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    // armed_q only rises after the line has been seen high while idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        armed_d = 1'b0;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            UART_IDLE: begin
                armed_d = rx_s;
                if (armed_q && !rx_s) begin
                    state_d = UART_START;
                    cnt_d   = '0;
                    div_d   = div_i;
                end
            end
            UART_START: begin
                cnt_d = cnt_q + DIV_W'(1);
                if (half) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rx_s ? UART_IDLE : UART_DATA;
                end
            end
            UART_DATA: begin
                cnt_d = cnt_q + DIV_W'(1);
                if (wrap) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = UART_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            UART_STOP: begin
                cnt_d = cnt_q + DIV_W'(1);
                if (wrap) begin
                    cnt_d   = '0;
                    state_d = UART_IDLE;
                    if (rx_s) begin
                        done_d = 1'b1;
                        byte_d = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    assign byte_done_o = done_q;
    assign byte_o      = byte_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: register file, TX serialiser and RX core hookup.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int unsigned DEFAULT_DIV = UART_DEFAULT_DIV,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  type_lsu2module_data_s lsu2uart_data,
    output type_module2lsu_s      uart2lsu_data,
    output logic                  tx,
    input  logic                  rx,
    output logic                  irq
);

    logic [1:0]           addr;
    logic                 acc_wr, acc_rd, rd_rx, tx_busy, tx_start;
    logic [BUS_WIDTH-1:0] rd_data_c;
    logic                 unused_bits;

    logic [DIV_W-1:0] baud_q, baud_d;
    uart_state_e      tx_state_q, tx_state_d;
    logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [DIV_W-1:0] tx_div_q, tx_div_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_q, tx_d;
    logic             tx_wrap;

    logic       rx_valid_q, rx_valid_d;
    logic       overrun_q, overrun_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       core_done, core_ferr;
    logic [7:0] core_byte;

    assign addr        = lsu2uart_data.dbus_addr[3:2];
    assign acc_wr      = lsu2uart_data.sel && lsu2uart_data.wr_en;
    assign acc_rd      = lsu2uart_data.sel && lsu2uart_data.rd_en;
    assign rd_rx       = acc_rd && (addr == REG_RXDATA);
    assign tx_busy     = (tx_state_q != UART_IDLE);
    assign tx_start    = acc_wr && (addr == REG_TXDATA) && !tx_busy;
    assign tx_wrap     = (tx_cnt_q == (tx_div_q - DIV_W'(1)));
    assign unused_bits = ^{lsu2uart_data.dbus[BUS_WIDTH-1:16],
                           lsu2uart_data.dbus_addr[BUS_WIDTH-1:4],
                           lsu2uart_data.dbus_addr[1:0]};

    uart_rx_core #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (rx),
        .div_i      (baud_q),
        .byte_done_o(core_done),
        .byte_o     (core_byte),
        .frame_err_o(core_ferr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_q      <= DIV_W'(DEFAULT_DIV);
            tx_state_q  <= UART_IDLE;
            tx_cnt_q    <= '0;
            tx_div_q    <= DIV_W'(DEFAULT_DIV);
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_q        <= 1'b1;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_byte_q   <= '0;
        end else begin
            baud_q      <= baud_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_div_q    <= tx_div_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rx_byte_q   <= rx_byte_d;
        end
    end

    // Register writes and receive flags; a byte landing on a RXDATA read edge wins.
    always_comb begin
        baud_d      = baud_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        rx_byte_d   = rx_byte_q;
        if (acc_wr && (addr == REG_BAUDDIV)) begin
            baud_d = clamp_div(lsu2uart_data.dbus[DIV_W-1:0]);
        end
        if (rd_rx) begin
            rx_valid_d  = 1'b0;
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (core_done) begin
            rx_byte_d  = core_byte;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rd_rx) begin
                overrun_d = 1'b1;
            end
        end
        if (core_ferr) begin
            frame_err_d = 1'b1;
        end
    end

    // TX serialiser: the divisor is captured at frame start.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        unique case (tx_state_q)
            UART_IDLE: begin
                tx_d = 1'b1;
                if (tx_start) begin
                    tx_state_d = UART_START;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_div_d   = baud_q;
                    tx_shift_d = lsu2uart_data.dbus[7:0];
                    tx_d       = 1'b0;
                end
            end
            UART_START: begin
                tx_cnt_d = tx_cnt_q + DIV_W'(1);
                if (tx_wrap) begin
                    tx_cnt_d   = '0;
                    tx_state_d = UART_DATA;
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                end
            end
            UART_DATA: begin
                tx_cnt_d = tx_cnt_q + DIV_W'(1);
                if (tx_wrap) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = UART_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                    end
                end
            end
            UART_STOP: begin
                tx_cnt_d = tx_cnt_q + DIV_W'(1);
                if (tx_wrap) begin
                    tx_cnt_d   = '0;
                    tx_state_d = UART_IDLE;
                end
            end
            default: begin
                tx_state_d = UART_IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    // Combinational read mux; no read side effects except on RXDATA.
    always_comb begin
        rd_data_c = '0;
        if (acc_rd) begin
            unique case (addr)
                REG_RXDATA:  rd_data_c = BUS_WIDTH'(rx_byte_q);
                REG_STATUS: begin
                    rd_data_c[ST_TX_BUSY]   = tx_busy;
                    rd_data_c[ST_RX_VALID]  = rx_valid_q;
                    rd_data_c[ST_OVERRUN]   = overrun_q;
                    rd_data_c[ST_FRAME_ERR] = frame_err_q;
                end
                REG_BAUDDIV: rd_data_c = BUS_WIDTH'(baud_q);
                default:     rd_data_c = '0;
            endcase
        end
    end

    always_comb begin
        uart2lsu_data         = '0;
        uart2lsu_data.rd_data = rd_data_c;
    end

    assign tx  = tx_q;
    assign irq = rx_valid_q;

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio: register table, TX waveform, RX flags and read/complete race.
module tb_uart_mmio;
    import uart_mmio_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    type_lsu2module_data_s req;
    type_module2lsu_s      resp;
    logic                  tx, rx, irq;
    int                    checks   = 0;
    int                    failures = 0;

    always #5 clk = ~clk;

    uart_mmio dut (
        .clk          (clk),
        .rst          (rst),
        .lsu2uart_data(req),
        .uart2lsu_data(resp),
        .tx           (tx),
        .rx           (rx),
        .irq          (irq)
    );

    typedef struct {
        logic        sel;
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, w, r, input logic [31:0] a, d, e, input string n);
        vec_t v;
        v.sel = s; v.wr = w; v.rd = r; v.addr = a; v.data = d; v.exp = e; v.name = n;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_set(input logic s, w, r, input logic [31:0] a, d);
        req.sel = s; req.wr_en = w; req.rd_en = r; req.dbus_addr = a; req.dbus = d;
    endtask

    task automatic bus_idle();
        req = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_read(input logic [31:0] a, input logic [31:0] exp, input string name);
        bus_set(1'b1, 1'b0, 1'b1, a, 32'h0);
        #1 check(name, resp.rd_data, exp);
        tick();
        bus_idle();
    endtask

    task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
        bus_set(1'b1, 1'b1, 1'b0, a, d);
        tick();
        bus_idle();
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(posedge clk);
        #1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        rx = 1'b1;
    endtask

    function automatic logic exp_tx(input int k, input logic [7:0] d);
        int b;
        b = k / 4;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    initial begin
        logic got;
        rst = 1'b1;
        rx  = 1'b1;
        req = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'h1);
        check("rst_irq", 32'(irq), 32'h0);
        @(negedge clk) rst = 1'b0;
        tick();

        // Reset in the middle of a frame at the default divisor.
        reg_write(32'h8000_0000, 32'h0000_0055);
        repeat (5) tick();
        check("tx_frame_low", 32'(tx), 32'h0);
        #2 rst = 1'b1;
        #1 check("tx_async_rst", 32'(tx), 32'h1);
        bus_set(1'b1, 1'b0, 1'b1, 32'h8000_0008, 32'h0);
        #1 check("status_in_rst", resp.rd_data, 32'h0);
        bus_idle();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        tick();
        check("irq_after_rst", 32'(irq), 32'h0);

        // Register access table: one bus cycle per vector.
        vecs.push_back(mk(1, 0, 1, 32'h8000_0008, 0, 32'h0, "status_reset"));
        vecs.push_back(mk(1, 0, 1, 32'h8000_000C, 0, 32'd434, "baud_reset"));
        vecs.push_back(mk(1, 0, 1, 32'h8000_0000, 0, 32'h0, "txdata_read0"));
        vecs.push_back(mk(1, 0, 1, 32'h8000_0004, 0, 32'h0, "rxdata_reset"));
        vecs.push_back(mk(1, 1, 1, 32'h8000_000C, 32'd2, 32'd434, "baud_wr_rd_old"));
        vecs.push_back(mk(1, 0, 1, 32'h8000_000C, 0, 32'd4, "baud_clamp2"));
        vecs.push_back(mk(1, 1, 0, 32'h8000_000C, 32'd1000, 32'h0, "rd_en_low"));
        vecs.push_back(mk(0, 0, 1, 32'h8000_000C, 0, 32'h0, "sel_low_read"));
        vecs.push_back(mk(1, 0, 1, 32'h1234_567C, 0, 32'd1000, "upper_addr"));
        vecs.push_back(mk(0, 1, 0, 32'h8000_000C, 32'd3, 32'h0, "sel_low_write"));
        vecs.push_back(mk(1, 0, 1, 32'h8000_000C, 0, 32'd1000, "baud_kept"));
        vecs.push_back(mk(1, 1, 0, 32'h8000_000C, 32'hABCD_0005, 32'h0, "baud_wr5"));
        vecs.push_back(mk(1, 0, 1, 32'h8000_000C, 0, 32'd5, "baud_16bit"));
        vecs.push_back(mk(1, 1, 0, 32'h8000_000C, 32'd0, 32'h0, "baud_wr0"));
        vecs.push_back(mk(1, 0, 1, 32'h8000_000C, 0, 32'd4, "baud_clamp0"));
        vecs.push_back(mk(1, 0, 1, 32'h8000_0008, 0, 32'h0, "status_idle"));
        foreach (vecs[i]) begin
            bus_set(vecs[i].sel, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data);
            #1 check(vecs[i].name, resp.rd_data, vecs[i].exp);
            tick();
            bus_idle();
        end

        // TX 0xA5 at divisor 4, with a dropped TXDATA write and a BAUDDIV write mid-frame.
        check("tx_idle_high", 32'(tx), 32'h1);
        bus_set(1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_00A5);
        tick();
        for (int k = 0; k < 50; k++) begin
            bus_idle();
            check($sformatf("tx_bit_k%0d", k), 32'(tx), 32'(exp_tx(k, 8'hA5)));
            if (k == 8) begin
                bus_set(1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_003C);
            end else if (k == 12) begin
                bus_set(1'b1, 1'b1, 1'b1, 32'h8000_000C, 32'd2);
                #1 check("baud_mid_frame", resp.rd_data, 32'd4);
            end else begin
                bus_set(1'b1, 1'b0, 1'b1, 32'h8000_0008, 32'h0);
                #1 check($sformatf("busy_k%0d", k), resp.rd_data, (k < 40) ? 32'h1 : 32'h0);
            end
            tick();
        end
        bus_idle();
        reg_read(32'h8000_000C, 32'd4, "baud_after_frame");

        // Single RX byte.
        send_rx(8'h5A, 1'b1);
        repeat (4) tick();
        check("rx_irq", 32'(irq), 32'h1);
        reg_read(32'h8000_0008, 32'h2, "rx_status_valid");
        reg_read(32'h8000_0004, 32'h5A, "rx_byte_5a");
        reg_read(32'h8000_0008, 32'h0, "rx_status_clr");
        check("rx_irq_clr", 32'(irq), 32'h0);

        // Overrun: two bytes without a read.
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        repeat (4) tick();
        reg_read(32'h8000_0008, 32'h6, "overrun_status");
        reg_read(32'h8000_0004, 32'h22, "overrun_byte");
        reg_read(32'h8000_0008, 32'h0, "overrun_clr");

        // One-cycle glitch is a false start.
        rx = 1'b0;
        tick();
        rx = 1'b1;
        repeat (60) tick();
        reg_read(32'h8000_0008, 32'h0, "glitch_status");
        check("glitch_irq", 32'(irq), 32'h0);

        // Stop bit low: frame error, byte discarded.
        send_rx(8'h99, 1'b0);
        repeat (4) tick();
        reg_read(32'h8000_0008, 32'h8, "ferr_status");
        check("ferr_irq", 32'(irq), 32'h0);

        // Read RXDATA continuously while 0x77 arrives; the completing edge coincides with a read.
        fork
            send_rx(8'h77, 1'b1);
        join_none
        got = 1'b0;
        bus_set(1'b1, 1'b0, 1'b1, 32'h8000_0004, 32'h0);
        for (int c = 0; c < 120 && !got; c++) begin
            #1 check("race_old_byte", resp.rd_data, 32'h22);
            tick();
            if (irq) begin
                got = 1'b1;
                bus_idle();
            end
        end
        bus_idle();
        check("race_irq_seen", 32'(got), 32'h1);
        repeat (2) tick();
        reg_read(32'h8000_0008, 32'h2, "race_status");
        reg_read(32'h8000_0004, 32'h77, "race_byte");
        reg_read(32'h8000_0008, 32'h0, "race_clr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
